// File: rtl/fft_out_reorder_if.sv
//------------------------------------------------------------------------------
// fft_out_reorder_if: sample-in / stream-out bundle of the FFT output reorder.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface fft_out_reorder_if #(
  parameter int FFT_SIZE = 16,
  parameter int DATA_W   = 16
);
  localparam int IDX_W = $clog2(FFT_SIZE);

  logic              din_valid;
  logic [DATA_W-1:0] din_re;
  logic [DATA_W-1:0] din_im;
  logic              dout_valid;
  logic              dout_ready;
  logic [DATA_W-1:0] dout_re;
  logic [DATA_W-1:0] dout_im;
  logic              dout_first;
  logic              dout_last;
  logic [IDX_W-1:0]  dout_idx;
  logic              overflow;
  logic              clr_overflow;

  // master: the reorder core, which sources the natural-order stream
  modport master (
    input  din_valid, din_re, din_im, dout_ready, clr_overflow,
    output dout_valid, dout_re, dout_im, dout_first, dout_last, dout_idx, overflow
  );

  modport slave (
    output din_valid, din_re, din_im, dout_ready, clr_overflow,
    input  dout_valid, dout_re, dout_im, dout_first, dout_last, dout_idx, overflow
  );
endinterface

`default_nettype wire

// File: rtl/fft_out_reorder.sv
//------------------------------------------------------------------------------
// fft_out_reorder: ping-pong buffer turning bit-reversed FFT output into a
// natural-order valid/ready stream with frame flags and overrun reporting.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module fft_out_reorder #(
  parameter int FFT_SIZE = 16,
  parameter int DATA_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  fft_out_reorder_if.master  bus
);
  localparam int IDX_W = $clog2(FFT_SIZE);
  localparam int SMP_W = 2 * DATA_W;
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(FFT_SIZE - 1);
  localparam logic [IDX_W-1:0] C_ZERO_IDX = '0;

  typedef enum logic [0:0] {
    R_IDLE   = 1'b0,
    R_STREAM = 1'b1
  } rd_state_t;

  function automatic logic [IDX_W-1:0] bit_reverse(input logic [IDX_W-1:0] v);
    for (int i = 0; i < IDX_W; i++) begin
      bit_reverse[i] = v[IDX_W-1-i];
    end
  endfunction

  logic [SMP_W-1:0]  mem_q [2][FFT_SIZE];

  logic [1:0]        full_q, full_d;
  logic              wbank_q, wbank_d;
  logic [IDX_W-1:0]  wcnt_q, wcnt_d;
  logic              overflow_q, overflow_d;

  rd_state_t         state_q;
  logic              rbank_q;
  logic [IDX_W-1:0]  rcnt_q;
  logic              dout_valid_q, dout_first_q, dout_last_q;
  logic [DATA_W-1:0] dout_re_q, dout_im_q;

  logic              w_accept, w_overrun, w_hs, w_release, w_other_bank;
  logic [IDX_W-1:0]  w_rnext;

  assign w_accept     = bus.din_valid & ~full_q[wbank_q];
  assign w_overrun    = bus.din_valid &  full_q[wbank_q];
  assign w_hs         = dout_valid_q & bus.dout_ready;
  assign w_release    = (state_q == R_STREAM) & w_hs & (rcnt_q == C_LAST_IDX);
  assign w_other_bank = ~rbank_q;
  assign w_rnext      = rcnt_q + 1'b1;

  // Release and completion always target different banks, so both may apply.
  always_comb begin
    full_d     = full_q;
    wbank_d    = wbank_q;
    wcnt_d     = wcnt_q;
    overflow_d = overflow_q;
    if (w_release) begin
      full_d[rbank_q] = 1'b0;
    end
    if (w_accept) begin
      wcnt_d = wcnt_q + 1'b1;
      if (wcnt_q == C_LAST_IDX) begin
        full_d[wbank_q] = 1'b1;
        wbank_d         = ~wbank_q;
      end
    end
    if (w_overrun) begin
      overflow_d = 1'b1;
    end else if (bus.clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q     <= 2'b00;
      wbank_q    <= 1'b0;
      wcnt_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      full_q     <= full_d;
      wbank_q    <= wbank_d;
      wcnt_q     <= wcnt_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      mem_q[wbank_q][bit_reverse(wcnt_q)] <= {bus.din_re, bus.din_im};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= R_IDLE;
      rbank_q      <= 1'b0;
      rcnt_q       <= '0;
      dout_valid_q <= 1'b0;
      dout_first_q <= 1'b0;
      dout_last_q  <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
    end else begin
      case (state_q)
        R_IDLE: begin
          if (full_q[rbank_q]) begin
            {dout_re_q, dout_im_q} <= mem_q[rbank_q][C_ZERO_IDX];
            rcnt_q       <= '0;
            dout_valid_q <= 1'b1;
            dout_first_q <= 1'b1;
            dout_last_q  <= 1'b0;
            state_q      <= R_STREAM;
          end
        end
        R_STREAM: begin
          if (w_hs) begin
            if (rcnt_q != C_LAST_IDX) begin
              {dout_re_q, dout_im_q} <= mem_q[rbank_q][w_rnext];
              rcnt_q       <= w_rnext;
              dout_first_q <= 1'b0;
              dout_last_q  <= (w_rnext == C_LAST_IDX);
            end else begin
              rbank_q     <= w_other_bank;
              rcnt_q      <= '0;
              dout_last_q <= 1'b0;
              // Back-to-back frames: start the other bank with no bubble.
              if (full_q[w_other_bank]) begin
                {dout_re_q, dout_im_q} <= mem_q[w_other_bank][C_ZERO_IDX];
                dout_valid_q <= 1'b1;
                dout_first_q <= 1'b1;
              end else begin
                dout_valid_q <= 1'b0;
                dout_first_q <= 1'b0;
                state_q      <= R_IDLE;
              end
            end
          end
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  assign bus.dout_valid = dout_valid_q;
  assign bus.dout_re    = dout_re_q;
  assign bus.dout_im    = dout_im_q;
  assign bus.dout_first = dout_first_q;
  assign bus.dout_last  = dout_last_q;
  assign bus.dout_idx   = rcnt_q;
  assign bus.overflow   = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
//------------------------------------------------------------------------------
// tb_fft_out_reorder: directed/randomized bench with a frame-queue reference model.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_fft_out_reorder;
  localparam int N     = 16;
  localparam int DW    = 16;
  localparam int IDX_W = $clog2(N);

  logic clk;
  logic rst_n;

  fft_out_reorder_if #(.FFT_SIZE(N), .DATA_W(DW)) bus ();

  fft_out_reorder #(.FFT_SIZE(N), .DATA_W(DW)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: accepted samples in arrival order, complete frames held.
  logic [2*DW-1:0] acc_q[$];
  int   nfull   = 0;
  int   wcnt    = 0;
  int   out_pos = 0;
  logic exp_ovf = 1'b0;
  bit   hold_v  = 1'b0;
  logic [63:0] sv_re, sv_im, sv_idx, sv_first, sv_last;

  function automatic int tb_bitrev(input int v);
    int r = 0;
    for (int i = 0; i < IDX_W; i++) begin
      if (((v >> i) & 1) != 0) r = r + (1 << (IDX_W - 1 - i));
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    acc_q.delete();
    nfull   = 0;
    wcnt    = 0;
    out_pos = 0;
    exp_ovf = 1'b0;
    hold_v  = 1'b0;
  endtask

  task automatic check_reset_outputs(input string phase);
    chk({phase, "_valid"}, bus.dout_valid, 0);
    chk({phase, "_first"}, bus.dout_first, 0);
    chk({phase, "_last"},  bus.dout_last,  0);
    chk({phase, "_re"},    bus.dout_re,    0);
    chk({phase, "_im"},    bus.dout_im,    0);
    chk({phase, "_idx"},   bus.dout_idx,   0);
    chk({phase, "_ovf"},   bus.overflow,   0);
  endtask

  // Called at 1 time unit after a rising edge; advances one clock.
  task automatic tick();
    int  pend;
    int  k;
    bit  hs;
    bit  last_hs;
    bit  drop;
    pend    = nfull;
    hs      = (bus.dout_valid === 1'b1) && (bus.dout_ready === 1'b1);
    last_hs = 1'b0;
    drop    = 1'b0;
    if (hold_v) begin
      chk("hold_valid", bus.dout_valid, 1);
      chk("hold_re",    bus.dout_re,    sv_re);
      chk("hold_im",    bus.dout_im,    sv_im);
      chk("hold_idx",   bus.dout_idx,   sv_idx);
      chk("hold_first", bus.dout_first, sv_first);
      chk("hold_last",  bus.dout_last,  sv_last);
    end
    if (bus.dout_valid === 1'b1 && pend == 0) chk("spurious_valid", bus.dout_valid, 0);
    if (hs && pend > 0) begin
      k = tb_bitrev(out_pos);
      chk("out_re",    bus.dout_re,    acc_q[k][2*DW-1:DW]);
      chk("out_im",    bus.dout_im,    acc_q[k][DW-1:0]);
      chk("out_idx",   bus.dout_idx,   out_pos);
      chk("out_first", bus.dout_first, out_pos == 0);
      chk("out_last",  bus.dout_last,  out_pos == N - 1);
      out_pos++;
      if (out_pos == N) begin
        for (int i = 0; i < N; i++) acc_q.delete(0);
        nfull--;
        out_pos = 0;
        last_hs = 1'b1;
      end
    end
    hold_v = (bus.dout_valid === 1'b1) && (bus.dout_ready !== 1'b1);
    if (hold_v) begin
      sv_re    = bus.dout_re;
      sv_im    = bus.dout_im;
      sv_idx   = bus.dout_idx;
      sv_first = bus.dout_first;
      sv_last  = bus.dout_last;
    end
    if (bus.din_valid) begin
      if (pend < 2) begin
        acc_q.push_back({bus.din_re, bus.din_im});
        wcnt++;
        if (wcnt == N) begin
          wcnt = 0;
          nfull++;
        end
      end else begin
        drop = 1'b1;
      end
    end
    if (drop) exp_ovf = 1'b1;
    else if (bus.clr_overflow) exp_ovf = 1'b0;
    @(posedge clk);
    #1;
    chk("overflow", bus.overflow, exp_ovf);
    if (last_hs) begin
      chk("next_valid", bus.dout_valid, pend >= 2);
      if (pend >= 2) begin
        chk("next_first", bus.dout_first, 1);
        chk("next_idx",   bus.dout_idx,   0);
      end
    end
  endtask

  task automatic drive_random_sample();
    bus.din_valid = 1'b1;
    bus.din_re    = DW'($urandom);
    bus.din_im    = DW'($urandom);
  endtask

  task automatic drain();
    int b = 0;
    bus.din_valid  = 1'b0;
    bus.dout_ready = 1'b1;
    while (nfull > 0 && b < 300) begin
      tick();
      b++;
    end
    chk("drain_done", nfull, 0);
    tick();
  endtask

  task automatic async_reset(input string phase);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs(phase);
    model_reset();
    bus.din_valid    = 1'b0;
    bus.clr_overflow = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    int sent;
    int cyc;
    rst_n            = 1'b0;
    bus.din_valid    = 1'b0;
    bus.din_re       = '0;
    bus.din_im       = '0;
    bus.dout_ready   = 1'b0;
    bus.clr_overflow = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 1: single frame, values bitrev(k), latency of two cycles after last input
    bus.dout_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      bus.din_valid = 1'b1;
      bus.din_re    = DW'(tb_bitrev(k));
      bus.din_im    = DW'(~tb_bitrev(k));
      tick();
    end
    bus.din_valid = 1'b0;
    chk("t1_lat_early", bus.dout_valid, 0);
    tick();
    chk("t1_lat_valid", bus.dout_valid, 1);
    chk("t1_lat_first", bus.dout_first, 1);
    chk("t1_lat_re",    bus.dout_re,    0);
    drain();

    // 2: three frames offered as fast as the buffer allows, ready held high
    sent = 0;
    cyc  = 0;
    while (sent < 3 * N && cyc < 500) begin
      if (nfull < 2) begin
        drive_random_sample();
        sent++;
      end else begin
        bus.din_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("t2_all_sent", sent, 3 * N);
    drain();

    // 3: random ready and input gaps, no overruns offered
    sent = 0;
    cyc  = 0;
    while (sent < 3 * N && cyc < 2000) begin
      bus.dout_ready = 1'($urandom_range(0, 1));
      if (nfull < 2 && $urandom_range(0, 3) != 0) begin
        drive_random_sample();
        sent++;
      end else begin
        bus.din_valid = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("t3_all_sent", sent, 3 * N);
    drain();

    // 4 and 6: fill both banks with ready low, overrun, clear collision, clear
    bus.dout_ready = 1'b0;
    for (int k = 0; k < 2 * N; k++) begin
      drive_random_sample();
      tick();
    end
    drive_random_sample();
    tick();
    chk("t4_ovf_set", bus.overflow, 1);
    drive_random_sample();
    bus.clr_overflow = 1'b1;
    tick();
    chk("t6_ovf_hold", bus.overflow, 1);
    bus.din_valid = 1'b0;
    tick();
    chk("t4_ovf_clr", bus.overflow, 0);
    bus.clr_overflow = 1'b0;
    drain();

    // 5: asynchronous reset while reading one frame and writing the next
    bus.dout_ready = 1'b1;
    for (int k = 0; k < N + N / 2; k++) begin
      drive_random_sample();
      tick();
    end
    chk("t5_mid_read", bus.dout_valid, 1);
    async_reset("t5_rst");
    for (int k = 0; k < N; k++) begin
      drive_random_sample();
      tick();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
